// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//   Shared types and helpers for the fifo_stream buffer.
//   - fifo_mode_e      : read-mode selector (registered read or first-word-fall-through)
//   - fifo_depth()     : entry count for a given address width
//   - fifo_ptr_width() : pointer/count width (address bits plus one wrap bit)
// ----------------------------------------------------------------------------
package fifo_pkg;

    typedef enum logic {
        FIFO_REG_READ = 1'b0,
        FIFO_FWFT     = 1'b1
    } fifo_mode_e;

    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // The extra bit distinguishes full from empty when the address bits match.
    function automatic int unsigned fifo_ptr_width(input int unsigned addr_width);
        return addr_width + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// ----------------------------------------------------------------------------
// fifo_ram
//   DEPTH x DATA_WIDTH storage array for fifo_stream. Contents are not reset.
//   Ports:
//     clk      in   write clock, rising edge
//     i_we     in   write enable
//     i_waddr  in   write address
//     i_wdata  in   write data
//     i_raddr  in   read address
//     o_rdata  out  read data, combinational from i_raddr
// ----------------------------------------------------------------------------
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_stream.sv
// ----------------------------------------------------------------------------
// fifo_stream
//   Single-clock stream FIFO with occupancy count, almost-full/almost-empty,
//   FWFT or registered-read mode, push-through when full, synchronous flush and
//   sticky overflow/underflow flags.
//   Ports:
//     clk, rst_n            clock (rising edge), async active-low reset
//     flush                 synchronous clear of contents; beats push/pop
//     push, wr_data         write request and data
//     pop                   read request
//     rd_data, rd_valid     read data and qualifier (mode dependent)
//     full, empty           occupancy status
//     almost_full/_empty    count >= AF_THRESH / count <= AE_THRESH
//     count                 occupancy 0..DEPTH
//     overflow, underflow   sticky rejected-push / rejected-pop flags
//     clr_err               synchronous clear of the sticky flags
// ----------------------------------------------------------------------------
module fifo_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter bit          FWFT       = 1'b1,
    parameter int unsigned AF_THRESH  = (32'd1 << ADDR_WIDTH) - 32'd1,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int unsigned PTR_W = fifo_ptr_width(ADDR_WIDTH);
    localparam fifo_mode_e  MODE  = fifo_mode_e'(FWFT);

    localparam logic [PTR_W-1:0] AF_LVL = AF_THRESH[PTR_W-1:0];
    localparam logic [PTR_W-1:0] AE_LVL = AE_THRESH[PTR_W-1:0];

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [PTR_W-1:0]      w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_acc;
    logic                  w_push_acc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [DATA_WIDTH-1:0] w_head;

    // Status is derived from the registered pointers only.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                     (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);

    // A push into a full FIFO is accepted only if the head leaves in the same cycle.
    assign w_pop_acc  = pop & ~w_empty & ~flush;
    assign w_push_acc = push & ~flush & (~w_full | w_pop_acc);
    assign w_ovf_set  = push & ~w_push_acc & ~flush;
    assign w_unf_set  = pop & ~w_pop_acc & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A set event in the same cycle as clr_err keeps the flag high.
            r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
            r_underflow <= w_unf_set | (r_underflow & ~clr_err);
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push_acc),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata (wr_data),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_head)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head is masked while empty so stale or uninitialised entries never leak out.
            assign rd_data  = w_empty ? '0 : w_head;
            assign rd_valid = ~w_empty;
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_pop_acc;
                    if (w_pop_acc) r_rd_data <= w_head;
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign count        = w_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (w_count >= AF_LVL);
    assign almost_empty = (w_count <= AE_LVL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_stream.sv
// ----------------------------------------------------------------------------
// tb_fifo_stream
//   Drives an FWFT instance (a_*) and a registered-read instance (b_*) with the
//   same stimulus and checks both against hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_fifo_stream;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       push;
    logic [7:0] wr_data;
    logic       pop;
    logic       clr_err;

    logic [7:0] a_rd_data, b_rd_data;
    logic       a_rd_valid, b_rd_valid;
    logic       a_full, b_full, a_empty, b_empty;
    logic       a_af, b_af, a_ae, b_ae;
    logic [3:0] a_count, b_count;
    logic       a_ovf, b_ovf, a_unf, b_unf;

    int n_checks;
    int n_fail;

    fifo_stream #(
        .DATA_WIDTH (8), .ADDR_WIDTH (3), .FWFT (1'b1), .AF_THRESH (6), .AE_THRESH (1)
    ) u_fwft (
        .clk (clk), .rst_n (rst_n), .flush (flush), .push (push), .wr_data (wr_data),
        .pop (pop), .rd_data (a_rd_data), .rd_valid (a_rd_valid), .full (a_full),
        .empty (a_empty), .almost_full (a_af), .almost_empty (a_ae), .count (a_count),
        .overflow (a_ovf), .underflow (a_unf), .clr_err (clr_err)
    );

    fifo_stream #(
        .DATA_WIDTH (8), .ADDR_WIDTH (3), .FWFT (1'b0), .AF_THRESH (6), .AE_THRESH (1)
    ) u_reg (
        .clk (clk), .rst_n (rst_n), .flush (flush), .push (push), .wr_data (wr_data),
        .pop (pop), .rd_data (b_rd_data), .rd_valid (b_rd_valid), .full (b_full),
        .empty (b_empty), .almost_full (b_af), .almost_empty (b_ae), .count (b_count),
        .overflow (b_ovf), .underflow (b_unf), .clr_err (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    // One clock with the given request inputs; samples are taken 1 time unit after the edge.
    task automatic step(input logic ps, input logic [7:0] d, input logic pp);
        push    = ps;
        wr_data = d;
        pop     = pp;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (a_count !== 4'd0 || b_count !== 4'd0 || a_empty !== 1'b1 || b_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_count: count %0d/%0d empty %b/%b, expected 0 and 1",
                     a_count, b_count, a_empty, b_empty);
        end
        n_checks++;
        if (a_full !== 1'b0 || b_full !== 1'b0 || a_af !== 1'b0 || b_af !== 1'b0 ||
            a_ae !== 1'b1 || b_ae !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_flags: full %b/%b af %b/%b ae %b/%b, expected 0,0,1",
                     a_full, b_full, a_af, b_af, a_ae, b_ae);
        end
        n_checks++;
        if (a_rd_data !== 8'h00 || b_rd_data !== 8'h00 || a_rd_valid !== 1'b0 ||
            b_rd_valid !== 1'b0 || a_ovf !== 1'b0 || b_ovf !== 1'b0 ||
            a_unf !== 1'b0 || b_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: rd_data %h/%h valid %b/%b ovf %b/%b unf %b/%b, expected 0",
                     a_rd_data, b_rd_data, a_rd_valid, b_rd_valid, a_ovf, b_ovf, a_unf, b_unf);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'(k), 1'b0);
            n_checks++;
            if (a_count !== 4'(k) || b_count !== 4'(k)) begin
                n_fail++;
                $display("FAIL fill_count: %0d/%0d, expected %0d", a_count, b_count, k);
            end
            n_checks++;
            if (a_af !== (k >= 6) || b_af !== (k >= 6) || a_full !== (k == 8) ||
                b_full !== (k == 8) || a_ae !== (k <= 1) || b_ae !== (k <= 1)) begin
                n_fail++;
                $display("FAIL fill_flags k=%0d: af %b/%b full %b/%b ae %b/%b", k, a_af, b_af,
                         a_full, b_full, a_ae, b_ae);
            end
        end
        n_checks++;
        if (a_rd_data !== 8'h01 || a_rd_valid !== 1'b1 || b_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_head: fwft %h v%b reg v%b, expected 01 v1 / v0",
                     a_rd_data, a_rd_valid, b_rd_valid);
        end
        step(1'b1, 8'h09, 1'b0);
        n_checks++;
        if (a_ovf !== 1'b1 || b_ovf !== 1'b1 || a_count !== 4'd8 || b_count !== 4'd8) begin
            n_fail++;
            $display("FAIL overflow: ovf %b/%b count %0d/%0d, expected 1 and 8",
                     a_ovf, b_ovf, a_count, b_count);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (a_rd_data !== 8'(i + 1) || a_rd_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_fwft %0d: %h v%b, expected %h", i, a_rd_data, a_rd_valid, i + 1);
            end
            step(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (b_rd_data !== 8'(i + 1) || b_rd_valid !== 1'b1 || b_count !== 4'(7 - i)) begin
                n_fail++;
                $display("FAIL drain_reg %0d: %h v%b count %0d, expected %h v1 count %0d", i,
                         b_rd_data, b_rd_valid, b_count, i + 1, 7 - i);
            end
        end
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (a_empty !== 1'b1 || b_empty !== 1'b1 || b_rd_valid !== 1'b0 || a_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drained: empty %b/%b valid %b/%b, expected 1,1,0,0",
                     a_empty, b_empty, a_rd_valid, b_rd_valid);
        end
        clr_err = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_ovf: %b/%b, expected 0", a_ovf, b_ovf);
        end
    endtask

    task automatic test_push_through();
        logic [7:0] exp_q [$];
        for (int k = 1; k <= 8; k++) step(1'b1, 8'(k), 1'b0);
        step(1'b1, 8'hAA, 1'b1);
        n_checks++;
        if (b_rd_data !== 8'h01 || b_rd_valid !== 1'b1 || a_count !== 4'd8 || b_count !== 4'd8 ||
            a_ovf !== 1'b0 || b_ovf !== 1'b0 || a_full !== 1'b1) begin
            n_fail++;
            $display("FAIL push_through: rd %h v%b count %0d/%0d ovf %b/%b full %b",
                     b_rd_data, b_rd_valid, a_count, b_count, a_ovf, b_ovf, a_full);
        end
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
        foreach (exp_q[i]) begin
            n_checks++;
            if (a_rd_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL pt_fwft %0d: %h, expected %h", i, a_rd_data, exp_q[i]);
            end
            step(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (b_rd_data !== exp_q[i]) begin
                n_fail++;
                $display("FAIL pt_reg %0d: %h, expected %h", i, b_rd_data, exp_q[i]);
            end
        end
    endtask

    task automatic test_empty_push_pop();
        step(1'b1, 8'h55, 1'b1);
        n_checks++;
        if (a_unf !== 1'b1 || b_unf !== 1'b1 || a_count !== 4'd1 || b_count !== 4'd1) begin
            n_fail++;
            $display("FAIL empty_pp: unf %b/%b count %0d/%0d, expected 1 and 1",
                     a_unf, b_unf, a_count, b_count);
        end
        n_checks++;
        if (a_rd_data !== 8'h55 || a_rd_valid !== 1'b1 || b_rd_valid !== 1'b0 ||
            b_rd_data !== 8'hAA) begin
            n_fail++;
            $display("FAIL empty_pp_read: fwft %h v%b reg %h v%b, expected 55 v1 / AA v0",
                     a_rd_data, a_rd_valid, b_rd_data, b_rd_valid);
        end
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (b_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reg_idle_valid: %b, expected 0", b_rd_valid);
        end
        step(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (b_rd_data !== 8'h55 || b_rd_valid !== 1'b1 || a_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reg_pop55: %h v%b empty %b, expected 55 v1 empty 1",
                     b_rd_data, b_rd_valid, a_empty);
        end
        clr_err = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (a_unf !== 1'b0 || b_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_unf: %b/%b, expected 0", a_unf, b_unf);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h10 + k), 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (a_rd_data !== 8'(8'h10 + i)) begin
                n_fail++;
                $display("FAIL wrap_fwft %0d: %h, expected %h", i, a_rd_data, 8'h10 + i);
            end
            step(1'b1, 8'(8'h13 + i), 1'b1);
            n_checks++;
            if (b_rd_data !== 8'(8'h10 + i) || a_count !== 4'd3 || b_count !== 4'd3) begin
                n_fail++;
                $display("FAIL wrap_reg %0d: %h count %0d/%0d, expected %h count 3", i,
                         b_rd_data, a_count, b_count, 8'h10 + i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (b_rd_data !== 8'(8'h24 + i)) begin
                n_fail++;
                $display("FAIL wrap_tail %0d: %h, expected %h", i, b_rd_data, 8'h24 + i);
            end
        end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h30 + k), 1'b0);
        n_checks++;
        if (a_count !== 4'd5 || b_count !== 4'd5) begin
            n_fail++;
            $display("FAIL pre_flush: %0d/%0d, expected 5", a_count, b_count);
        end
        flush = 1'b1;
        step(1'b1, 8'hEE, 1'b1);
        n_checks++;
        if (a_count !== 4'd0 || b_count !== 4'd0 || a_empty !== 1'b1 || b_empty !== 1'b1 ||
            a_ovf !== 1'b0 || b_ovf !== 1'b0 || a_unf !== 1'b0 || b_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: count %0d/%0d empty %b/%b ovf %b/%b unf %b/%b",
                     a_count, b_count, a_empty, b_empty, a_ovf, b_ovf, a_unf, b_unf);
        end
        n_checks++;
        if (a_rd_valid !== 1'b0 || b_rd_valid !== 1'b0 || b_rd_data !== 8'h26) begin
            n_fail++;
            $display("FAIL flush_read: valid %b/%b reg %h, expected 0,0,26",
                     a_rd_valid, b_rd_valid, b_rd_data);
        end
        for (int k = 0; k < 9; k++) step(1'b1, 8'(8'h60 + k), 1'b0);
        // Rejected push coinciding with clr_err: the new event keeps the flag set.
        clr_err = 1'b1;
        step(1'b1, 8'h77, 1'b0);
        n_checks++;
        if (a_ovf !== 1'b1 || b_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_set: %b/%b, expected 1", a_ovf, b_ovf);
        end
        clr_err = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (a_ovf !== 1'b0 || b_ovf !== 1'b0 || a_full !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_err: ovf %b/%b full %b, expected 0 and full 1", a_ovf, b_ovf, a_full);
        end
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h40 + k), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (a_count !== 4'd4 || b_unf !== 1'b1 || b_rd_valid !== 1'b1 || b_rd_data !== 8'h40) begin
            n_fail++;
            $display("FAIL pre_reset: count %0d unf %b reg %h v%b, expected 4,1,40,1",
                     a_count, b_unf, b_rd_data, b_rd_valid);
        end
        push = 1'b1; wr_data = 8'h45;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_count !== 4'd0 || b_count !== 4'd0 || a_empty !== 1'b1 || a_full !== 1'b0 ||
            a_ae !== 1'b1 || a_af !== 1'b0 || b_ae !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_state: count %0d/%0d empty %b full %b ae %b/%b af %b",
                     a_count, b_count, a_empty, a_full, a_ae, b_ae, a_af);
        end
        n_checks++;
        if (a_rd_data !== 8'h00 || b_rd_data !== 8'h00 || a_rd_valid !== 1'b0 ||
            b_rd_valid !== 1'b0 || a_unf !== 1'b0 || b_unf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_read: %h/%h v%b/%b unf %b/%b, expected zeros",
                     a_rd_data, b_rd_data, a_rd_valid, b_rd_valid, a_unf, b_unf);
        end
        push = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill();
        test_push_through();
        test_empty_push_pop();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
